// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mole_scheduler
// Brief    : Keeps up to MAX_MOLES moles alive on distinct holes, ages them on
//            game ticks, respawns via LFSR draws and resolves whack requests.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module mole_scheduler #(
  parameter int          NUM_HOLES = 18,
  parameter int          MAX_MOLES = 3,
  parameter int          LIFE_W    = 4,
  parameter int          MAX_TRIES = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               tick,
  input  logic [$clog2(MAX_MOLES+1)-1:0]     target_moles,
  input  logic [LIFE_W-1:0]                  lifetime,
  input  logic                               whack_valid,
  input  logic [$clog2(NUM_HOLES)-1:0]       whack_hole,
  output logic [NUM_HOLES-1:0]               mole_mask,
  output logic [$clog2(MAX_MOLES+1)-1:0]     live_count,
  output logic                               hit_pulse,
  output logic [$clog2(NUM_HOLES)-1:0]       hit_hole,
  output logic                               miss_pulse,
  output logic                               busy
);

  localparam int c_IDX_W = $clog2(NUM_HOLES);
  localparam int c_CNT_W = $clog2(MAX_MOLES+1);
  localparam int c_TRY_W = $clog2(MAX_TRIES+2);
  localparam int c_PAD_W = 2**c_IDX_W;
  localparam logic [LIFE_W-1:0]  c_LIFE_ONE = LIFE_W'(1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_MOLES);
  localparam logic [c_TRY_W-1:0] c_MAX_TRY  = c_TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AGE   = 2'd1,
    ST_PICK  = 2'd2,
    ST_PLACE = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_lfsr;
  logic                  r_prev_tick;
  logic [MAX_MOLES-1:0]  r_valid, w_valid_nxt;
  logic [c_IDX_W-1:0]    r_hole [MAX_MOLES];
  logic [c_IDX_W-1:0]    w_hole_nxt [MAX_MOLES];
  logic [LIFE_W-1:0]     r_timer [MAX_MOLES];
  logic [LIFE_W-1:0]     w_timer_nxt [MAX_MOLES];
  logic [NUM_HOLES-1:0]  r_mask, w_mask_nxt;
  logic [c_CNT_W-1:0]    r_live, w_live_nxt;
  logic                  r_hit, w_hit;
  logic [c_IDX_W-1:0]    r_hit_hole, w_hit_hole;
  logic                  r_miss, w_miss;
  logic [c_IDX_W-1:0]    r_cand, w_cand_nxt;
  logic [c_TRY_W-1:0]    r_tries, w_tries_nxt;

  logic                  w_tick_rise;
  logic                  w_lfsr_fb;
  logic [LIFE_W-1:0]     w_life;
  logic [c_CNT_W-1:0]    w_target;
  logic [c_IDX_W-1:0]    w_draw;
  logic [c_PAD_W-1:0]    w_occ_pad;
  logic                  w_accept;
  logic [c_IDX_W-1:0]    w_fallback;
  logic                  w_fb_found;
  logic                  w_slot_found;
  logic [MAX_MOLES-1:0]  w_whacked;

  assign w_tick_rise = tick & ~r_prev_tick;
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_life      = (lifetime == '0) ? c_LIFE_ONE : lifetime;
  assign w_target    = (target_moles > c_MAX_CNT) ? c_MAX_CNT : target_moles;
  assign w_draw      = r_lfsr[c_IDX_W-1:0];

  // Occupancy padded with ones so draws beyond the last hole read as taken.
  always_comb begin
    w_occ_pad = '1;
    w_occ_pad[NUM_HOLES-1:0] = r_mask;
  end

  assign w_accept = ~w_occ_pad[w_draw];

  // Priority encoder: lowest-index free hole used when random draws give up.
  always_comb begin
    w_fallback = '0;
    w_fb_found = 1'b0;
    for (int h = 0; h < NUM_HOLES; h++) begin
      if (!w_fb_found && !r_mask[h]) begin
        w_fallback = c_IDX_W'(h);
        w_fb_found = 1'b1;
      end
    end
  end

  // Next slot contents: whack frees, aging/expiry, placement, enable clear.
  always_comb begin
    w_valid_nxt  = r_valid;
    w_hole_nxt   = r_hole;
    w_timer_nxt  = r_timer;
    w_whacked    = '0;
    w_hit        = 1'b0;
    w_hit_hole   = r_hit_hole;
    w_miss       = 1'b0;
    w_slot_found = 1'b0;
    for (int i = 0; i < MAX_MOLES; i++) begin
      if (whack_valid && (int'(whack_hole) < NUM_HOLES) &&
          r_valid[i] && (r_hole[i] == whack_hole)) begin
        w_whacked[i]   = 1'b1;
        w_valid_nxt[i] = 1'b0;
        w_hit          = 1'b1;
        w_hit_hole     = whack_hole;
      end
    end
    if (r_state == ST_AGE) begin
      for (int i = 0; i < MAX_MOLES; i++) begin
        if (r_valid[i]) begin
          w_timer_nxt[i] = r_timer[i] - c_LIFE_ONE;
          if (r_timer[i] == c_LIFE_ONE) begin
            w_valid_nxt[i] = 1'b0;
            // A whack landing on an expiring mole scores as a hit only.
            if (!w_whacked[i]) w_miss = 1'b1;
          end
        end
      end
    end
    if (r_state == ST_PLACE) begin
      for (int i = 0; i < MAX_MOLES; i++) begin
        if (!w_slot_found && !r_valid[i]) begin
          w_valid_nxt[i] = 1'b1;
          w_hole_nxt[i]  = r_cand;
          w_timer_nxt[i] = w_life;
          w_slot_found   = 1'b1;
        end
      end
    end
    if (!enable) begin
      w_valid_nxt = '0;
      w_hit       = 1'b0;
      w_hit_hole  = r_hit_hole;
      w_miss      = 1'b0;
    end
  end

  // Derived mask and live count from the next slot contents, kept in lockstep.
  always_comb begin
    w_mask_nxt = '0;
    w_live_nxt = '0;
    for (int i = 0; i < MAX_MOLES; i++) begin
      if (w_valid_nxt[i]) begin
        w_mask_nxt[w_hole_nxt[i]] = 1'b1;
        w_live_nxt = w_live_nxt + c_CNT_W'(1);
      end
    end
  end

  // Scheduler FSM next-state: age on tick, then draw and place until target.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_tries_nxt = r_tries;
    case (r_state)
      ST_IDLE: begin
        if (w_tick_rise && enable) w_state_nxt = ST_AGE;
      end
      ST_AGE: begin
        w_tries_nxt = '0;
        w_state_nxt = (w_live_nxt < w_target) ? ST_PICK : ST_IDLE;
      end
      ST_PICK: begin
        if (r_tries == c_MAX_TRY) begin
          w_cand_nxt  = w_fallback;
          w_state_nxt = ST_PLACE;
        end else if (w_accept) begin
          w_cand_nxt  = w_draw;
          w_state_nxt = ST_PLACE;
        end else begin
          w_tries_nxt = r_tries + c_TRY_W'(1);
        end
      end
      ST_PLACE: begin
        w_tries_nxt = '0;
        w_state_nxt = (w_live_nxt < w_target) ? ST_PICK : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_tries_nxt = '0;
    end
  end

  // Free-running LFSR and tick edge history, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= SEED;
      r_prev_tick <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
      r_prev_tick <= tick;
    end
  end

  // FSM, slot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_valid    <= '0;
      r_mask     <= '0;
      r_live     <= '0;
      r_hit      <= 1'b0;
      r_hit_hole <= '0;
      r_miss     <= 1'b0;
      r_cand     <= '0;
      r_tries    <= '0;
      for (int i = 0; i < MAX_MOLES; i++) begin
        r_hole[i]  <= '0;
        r_timer[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_mask     <= w_mask_nxt;
      r_live     <= w_live_nxt;
      r_hit      <= w_hit;
      r_hit_hole <= w_hit_hole;
      r_miss     <= w_miss;
      r_cand     <= w_cand_nxt;
      r_tries    <= w_tries_nxt;
      for (int i = 0; i < MAX_MOLES; i++) begin
        r_hole[i]  <= w_hole_nxt[i];
        r_timer[i] <= w_timer_nxt[i];
      end
    end
  end

  assign mole_mask  = r_mask;
  assign live_count = r_live;
  assign hit_pulse  = r_hit;
  assign hit_hole   = r_hit_hole;
  assign miss_pulse = r_miss;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Parametrised successor to the fixed three-mole generator.
- Keeps up to MAX_MOLES moles alive at once, each on a distinct hole, each with its own lifetime counted in game ticks.
- Accepts whack requests from the input decoder. Reports hits and expiries (misses) to the scoring logic.
- Drives the hole bitmap used by the display and LED drivers.

Parameters:
- NUM_HOLES, 18, number of holes; legal 2..64.
- MAX_MOLES, 3, mole slots; must be < NUM_HOLES.
- LIFE_W, 4, width of lifetime and per-slot timers.
- MAX_TRIES, 4, random draws before falling back to lowest free hole.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = game running; 0 = clear all moles, freeze.
- tick  in  1  level game-tick signal; rising edge detected internally.
- target_moles  in  $clog2(MAX_MOLES+1)  desired live count; clamped to MAX_MOLES.
- lifetime  in  LIFE_W  ticks a new mole lives; 0 is treated as 1.
- whack_valid  in  1  one-cycle whack strobe.
- whack_hole  in  $clog2(NUM_HOLES)  hole whacked.
- mole_mask  out  NUM_HOLES  1 per occupied hole.
- live_count  out  $clog2(MAX_MOLES+1)  number of occupied slots.
- hit_pulse  out  1  one-cycle pulse on a successful whack.
- hit_hole  out  $clog2(NUM_HOLES)  hole of the last hit; held until the next hit.
- miss_pulse  out  1  one-cycle pulse for each tick on which at least one mole expired.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - All slots are free.
  - LFSR = SEED.
  - prev_tick = 0.
  - FSM is in IDLE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk while rst_n is high, regardless of enable.
- Tick edge: tick_rise = tick & ~prev_tick, with prev_tick registered each cycle.
- Slot state: valid, hole index, timer (LIFE_W). mole_mask is the OR of decoded holes of valid slots, registered.
- FSM:
  - IDLE:
    - tick_rise & enable -> AGE.
    - Otherwise stay.
  - AGE (1 cycle):
    - Every valid slot decrements its timer.
    - A slot whose timer was 1 is freed.
    - If any slot is freed here, miss_pulse = 1 on the next cycle.
    - -> PICK if live_count after aging < clamped target_moles, else IDLE.
  - PICK:
    - Candidate = LFSR[IDX_W-1:0] mod-free: accept only if candidate < NUM_HOLES and the hole is unoccupied.
    - Accept -> PLACE.
    - Reject -> retry the next cycle with a new LFSR value.
    - After MAX_TRIES rejects, take the lowest-index free hole (priority encoder) -> PLACE.
  - PLACE (1 cycle):
    - Lowest-index free slot gets valid = 1, hole = candidate, timer = max(lifetime,1).
    - -> PICK if still below target, else IDLE.
- Spawn latency: first mole is visible in mole_mask 3 cycles after tick_rise at best (AGE, PICK, PLACE + register). Worst case per mole is MAX_TRIES+2 cycles.
- Ticks while busy:
  - Not queued; dropped.
  - prev_tick still updates.
- Whack:
  - Evaluated every cycle in any state, against the current registered slots.
  - On a match, the slot is freed at the next edge, hit_pulse = 1 for one cycle, and hit_hole is updated.
  - Whack on an empty hole or a hole ≥ NUM_HOLES: no effect.
- Same-cycle conflicts:
  - Whack and AGE expiry on the same slot: counts as a hit only; the miss for that slot is suppressed.
  - Whack on the hole being placed in PLACE that cycle: no hit. The new mole appears.
  - A hole freed by a whack during PICK may be chosen again.
- target_moles reduced below live_count: no moles are removed; they simply are not replaced.
- enable low:
  - Next edge clears all slots and mole_mask, FSM -> IDLE.
  - No pulses.
  - LFSR keeps running.
- rst_n low at any time, including mid-PICK: immediately returns to reset values.
- live_count is registered and consistent with mole_mask on the same cycle.

Test Plan:
- Reset, enable = 1, target = 3, lifetime = 2, one tick -> within 3..3·(MAX_TRIES+2)+1 cycles: mole_mask has exactly 3 distinct bits, live_count = 3, busy returns 0.
- Continue ticks, no whacks -> on the 2nd tick all 3 expire: one miss_pulse, then 3 fresh moles are placed; no hole is ever set twice; live_count never exceeds 3.
- Whack an occupied hole k -> next cycle: hit_pulse = 1, hit_hole = k, bit k cleared, live_count = 2. Whack an empty hole -> no pulse, mask unchanged.
- Whack a mole on its expiring tick, same cycle as AGE -> hit_pulse = 1, miss_pulse = 0 if it was the only expiring mole.
- NUM_HOLES = 4, MAX_MOLES = 3, force SEED so draws collide -> fallback fills the lowest free hole after 4 rejects; mask = 3 distinct bits.
- Assert rst_n = 0 mid-PICK, and separately drop enable with 3 live moles -> all outputs 0 and FSM IDLE; with enable low, mask clears in one cycle and no pulses are emitted.
